// File: rtl/ifu_f.sv
// ifu_f: instruction fetch stage with F/D pipeline register.
//
// Holds the fetch PC and selects the next PC. The next PC can be sequential,
// a taken branch, a j/jal, or a jr/jalr. Control transfers have one delay
// slot: the redirect comes from the instruction currently in D.
// Checks each fetch address against the instruction-memory window and flags
// any fetch outside it.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   stall      1 = hold pc_F and the F/D register
//   clr_D      1 = load a nop bubble into F/D (stall has priority)
//   npc_sel    next-PC source: 00 seq, 01 branch, 10 j/jal, 11 jr/jalr
//   br_taken   branch condition, used when npc_sel = 01
//   imm16_D    branch offset of the D-stage instruction
//   idx26_D    jump index of the D-stage instruction
//   jr_target  forwarded register value for jr/jalr
//   im_addr    word address to instruction memory (pc_F[11:2])
//   im_instr   instruction word from memory (combinational)
//   pc_F       current fetch PC
//   instr_D    instruction in D
//   pc_D       PC of instr_D
//   pc8_D      pc_D + 8 (link address)
//   ferr_D     fetch error flag for instr_D
module ifu_f #(
    parameter logic [31:0] PC_INIT  = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        clr_D,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16_D,
    input  logic [25:0] idx26_D,
    input  logic [31:0] jr_target,
    output logic [9:0]  im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] pc_F,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        ferr_D
);

    // The window end is computed with 33 bits so that a window touching
    // 2^32 does not wrap to a small value.
    localparam logic [32:0] IM_END = {1'b0, PC_INIT} + 33'(4 * IM_WORDS);

    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] fd_instr_q, fd_instr_d;
    logic [31:0] fd_pc_q, fd_pc_d;
    logic        fd_ferr_q, fd_ferr_d;

    logic [31:0] pc_seq;
    logic [31:0] br_off;
    logic [31:0] npc;
    logic        fetch_err;

    always_comb begin
        pc_seq = pc_f_q + 32'd4;
        br_off = {{14{imm16_D[15]}}, imm16_D, 2'b00};
        npc    = pc_seq;
        case (npc_sel)
            2'b00: npc = pc_seq;
            2'b01: npc = br_taken ? (fd_pc_q + 32'd4 + br_off) : pc_seq;
            2'b10: npc = {fd_pc_q[31:28], idx26_D, 2'b00};
            2'b11: npc = jr_target;
            default: npc = pc_seq;
        endcase
    end

    always_comb begin
        fetch_err = (pc_f_q[1:0] != 2'b00)
                 || (pc_f_q < PC_INIT)
                 || ({1'b0, pc_f_q} >= IM_END);
    end

    always_comb begin
        pc_f_d     = pc_f_q;
        fd_instr_d = fd_instr_q;
        fd_pc_d    = fd_pc_q;
        fd_ferr_d  = fd_ferr_q;
        if (!stall) begin
            pc_f_d = npc;
            if (clr_D) begin
                fd_instr_d = 32'd0;
                fd_pc_d    = 32'd0;
                fd_ferr_d  = 1'b0;
            end else if (fetch_err) begin
                // A bad fetch becomes a nop but keeps its PC so the
                // fault can be attributed later.
                fd_instr_d = 32'd0;
                fd_pc_d    = pc_f_q;
                fd_ferr_d  = 1'b1;
            end else begin
                fd_instr_d = im_instr;
                fd_pc_d    = pc_f_q;
                fd_ferr_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f_q     <= PC_INIT;
            fd_instr_q <= 32'd0;
            fd_pc_q    <= 32'd0;
            fd_ferr_q  <= 1'b0;
        end else begin
            pc_f_q     <= pc_f_d;
            fd_instr_q <= fd_instr_d;
            fd_pc_q    <= fd_pc_d;
            fd_ferr_q  <= fd_ferr_d;
        end
    end

    assign im_addr = pc_f_q[11:2];
    assign pc_F    = pc_f_q;
    assign instr_D = fd_instr_q;
    assign pc_D    = fd_pc_q;
    assign pc8_D   = fd_pc_q + 32'd8;
    assign ferr_D  = fd_ferr_q;

endmodule

// File: tb/tb_ifu_f.sv
module tb_ifu_f;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        clr_D;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [15:0] imm16_D;
    logic [25:0] idx26_D;
    logic [31:0] jr_target;
    logic [9:0]  im_addr;
    logic [31:0] im_instr;
    logic [31:0] pc_F;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        ferr_D;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [31:0] m_pc_f, m_instr, m_pc_d;
    logic        m_ferr;

    always #5 clk = ~clk;

    assign im_instr = mem[im_addr];

    ifu_f dut (
        .clk(clk), .reset(reset), .stall(stall), .clr_D(clr_D),
        .npc_sel(npc_sel), .br_taken(br_taken), .imm16_D(imm16_D),
        .idx26_D(idx26_D), .jr_target(jr_target), .im_addr(im_addr),
        .im_instr(im_instr), .pc_F(pc_F), .instr_D(instr_D), .pc_D(pc_D),
        .pc8_D(pc8_D), .ferr_D(ferr_D)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: instruction memory covers byte addresses [0x3000, 0x4000).
    function automatic logic bad_addr(input logic [31:0] a);
        longint ua;
        ua = longint'(a);
        return (a[1:0] != 2'b00) || (ua < 64'h3000) || (ua >= 64'h3000 + 4 * 1024);
    endfunction

    task automatic model_edge();
        logic [31:0] nxt;
        longint      off;
        if (!reset) begin
            m_pc_f = 32'h3000; m_instr = 0; m_pc_d = 0; m_ferr = 0;
            return;
        end
        if (stall) return;
        off = longint'($signed(imm16_D)) * 4;
        if (npc_sel == 2'd1 && br_taken)
            nxt = 32'(longint'(m_pc_d) + 4 + off);
        else if (npc_sel == 2'd2)
            nxt = (m_pc_d & 32'hF000_0000) | (32'(idx26_D) * 4);
        else if (npc_sel == 2'd3)
            nxt = jr_target;
        else
            nxt = m_pc_f + 4;
        if (clr_D) begin
            m_instr = 0; m_pc_d = 0; m_ferr = 0;
        end else if (bad_addr(m_pc_f)) begin
            m_instr = 0; m_pc_d = m_pc_f; m_ferr = 1;
        end else begin
            m_instr = mem[(m_pc_f / 4) % 1024]; m_pc_d = m_pc_f; m_ferr = 0;
        end
        m_pc_f = nxt;
    endtask

    task automatic compare_all();
        check("pc_F", pc_F, m_pc_f);
        check("im_addr", 32'(im_addr), (m_pc_f / 4) % 1024);
        check("instr_D", instr_D, m_instr);
        check("pc_D", pc_D, m_pc_d);
        check("pc8_D", pc8_D, m_pc_d + 8);
        check("ferr_D", 32'(ferr_D), 32'(m_ferr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        reset = 1; stall = 0; clr_D = 0; npc_sel = 0; br_taken = 0;
        imm16_D = 0; idx26_D = 0; jr_target = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        step();
        reset = 1;
    endtask

    logic [31:0] hold_pc, hold_instr;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom();
        m_pc_f = 0; m_instr = 0; m_pc_d = 0; m_ferr = 0;
        idle_inputs();
        stall = 1; clr_D = 1; npc_sel = 2'd3; jr_target = 32'h1234;
        reset = 0;
        step();
        check("rst_pc", pc_F, 32'h3000);
        check("rst_addr", 32'(im_addr), 0);
        check("rst_instr", instr_D, 0);
        check("rst_ferr", 32'(ferr_D), 0);
        idle_inputs();

        // three sequential cycles
        for (int i = 1; i <= 3; i++) begin
            step();
            check("seq_pc", pc_F, 32'h3000 + 32'(4 * i));
            check("seq_addr", 32'(im_addr), 32'(i));
        end

        // taken branch back to itself, delay slot enters D
        do_reset();
        step(); step();
        check("br_pre_pcD", pc_D, 32'h3004);
        npc_sel = 2'd1; br_taken = 1; imm16_D = 16'hFFFF;
        step();
        check("br_pc", pc_F, 32'h3004);
        check("br_slot_pc", pc_D, 32'h3008);
        check("br_slot_instr", instr_D, mem[2]);
        idle_inputs();

        // jr to misaligned address, error on the following edge
        do_reset();
        repeat (5) step();
        check("jr_pre_pcD", pc_D, 32'h3010);
        npc_sel = 2'd3; jr_target = 32'h3002;
        step();
        check("jr_pc", pc_F, 32'h3002);
        idle_inputs();
        step();
        check("jr_ferr", 32'(ferr_D), 1);
        check("jr_instr", instr_D, 0);
        check("jr_pcD", pc_D, 32'h3002);

        // stall holds through a pending jump
        do_reset();
        step(); step();
        hold_pc = pc_F; hold_instr = instr_D;
        stall = 1; npc_sel = 2'd2; idx26_D = 26'h0C10;
        repeat (2) begin
            step();
            check("stall_pc", pc_F, hold_pc);
            check("stall_instr", instr_D, hold_instr);
        end
        stall = 0;
        step();
        check("jump_pc", pc_F, 32'h3040);
        idle_inputs();

        // stall beats clr_D, then clr_D alone
        hold_pc = pc_F; hold_instr = instr_D;
        stall = 1; clr_D = 1;
        step();
        check("stclr_pc", pc_F, hold_pc);
        check("stclr_instr", instr_D, hold_instr);
        stall = 0;
        step();
        check("clr_instr", instr_D, 0);
        check("clr_ferr", 32'(ferr_D), 0);
        check("clr_pcD", pc_D, 0);
        check("clr_pc", pc_F, hold_pc + 4);
        idle_inputs();

        // end of window, then reset while a redirect is in D
        npc_sel = 2'd3; jr_target = 32'h3FFC;
        step();
        idle_inputs();
        step();
        check("end_pc", pc_F, 32'h4000);
        check("end_last_ok", 32'(ferr_D), 0);
        step();
        check("end_ferr", 32'(ferr_D), 1);
        check("end_pcD", pc_D, 32'h4000);
        check("wrap_keep_pc", pc_F, 32'h4004);
        reset = 0; npc_sel = 2'd3; jr_target = 32'h3100;
        step();
        check("rst_mid_pc", pc_F, 32'h3000);
        idle_inputs();
        step();
        check("rst_first_fetch", pc_D, 32'h3000);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            reset    = ($urandom_range(99) != 0);
            stall    = ($urandom_range(4) == 0);
            clr_D    = ($urandom_range(9) == 0);
            npc_sel  = 2'($urandom_range(3));
            br_taken = 1'($urandom_range(1));
            r = $urandom_range(9);
            imm16_D  = (r == 0) ? 16'($urandom()) : 16'($urandom_range(16) - 8);
            r = $urandom_range(9);
            idx26_D  = (r == 0) ? 26'($urandom()) : 26'((32'h3000 + 4 * $urandom_range(1023)) >> 2);
            r = $urandom_range(9);
            jr_target = (r == 0) ? $urandom() : 32'h3000 + 4 * $urandom_range(1023);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
